// File: rtl/stopwatch_timer.sv
// Stopwatch / countdown timer with a tick prescaler, a start/pause FSM and a lap-capture FIFO.
// The count and all status outputs are registered. Only the FIFO head is driven combinationally.
module stopwatch_timer #(
   parameter int TICK_DIV  = 100000,
   parameter int MAX_MIN   = 60,
   parameter int LAP_DEPTH = 4,
   localparam int MIN_W    = (MAX_MIN > 1) ? $clog2(MAX_MIN) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             clear,
   input  logic             mode,
   input  logic [6:0]       load_cs,
   input  logic [5:0]       load_sec,
   input  logic [MIN_W-1:0] load_min,
   input  logic             lap,
   input  logic             lap_rd,
   output logic [6:0]       cs_out,
   output logic [5:0]       sec_out,
   output logic [MIN_W-1:0] min_out,
   output logic             running,
   output logic             expired,
   output logic [6:0]       lap_cs,
   output logic [5:0]       lap_sec,
   output logic [MIN_W-1:0] lap_min,
   output logic             lap_valid,
   output logic             lap_full,
   output logic             lap_ovf
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
   localparam int CW = $clog2(LAP_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   typedef struct packed {
      logic [MIN_W-1:0] min;
      logic [5:0]       sec;
      logic [6:0]       cs;
   } lap_t;

   state_t           state, state_nx;
   logic [PW-1:0]    presc;
   logic             mode_q;
   logic             tick, at_zero, down_zero;
   logic [6:0]       cs_nx;
   logic [5:0]       sec_nx;
   logic [MIN_W-1:0] min_nx;

   assign at_zero = (cs_out == 7'd0) && (sec_out == 6'd0) && (min_out == '0);
   assign tick    = (state == RUN) && (presc == PW'(TICK_DIV - 1));

   // Count value after one tick in the direction latched while idle
   always_comb begin
      cs_nx  = cs_out;
      sec_nx = sec_out;
      min_nx = min_out;
      if (!mode_q) begin
         if (cs_out == 7'd99) begin
            cs_nx = 7'd0;
            if (sec_out == 6'd59) begin
               sec_nx = 6'd0;
               min_nx = (min_out == MIN_W'(MAX_MIN - 1)) ? '0 : min_out + 1'b1;
            end else begin
               sec_nx = sec_out + 6'd1;
            end
         end else begin
            cs_nx = cs_out + 7'd1;
         end
      end else begin
         if (cs_out == 7'd0) begin
            cs_nx = 7'd99;
            if (sec_out == 6'd0) begin
               sec_nx = 6'd59;
               min_nx = min_out - 1'b1;
            end else begin
               sec_nx = sec_out - 6'd1;
            end
         end else begin
            cs_nx = cs_out - 7'd1;
         end
      end
   end

   assign down_zero = mode_q && (cs_nx == 7'd0) && (sec_nx == 6'd0) && (min_nx == '0);

   always_comb begin
      state_nx = state;
      if (clear) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (start && !(mode && at_zero)) state_nx = RUN;
            RUN:     if (tick && down_zero)           state_nx = DONE;
                     else if (start)                  state_nx = PAUSE;
            PAUSE:   if (start)                       state_nx = RUN;
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         running <= 1'b0;
         expired <= 1'b0;
         mode_q  <= 1'b0;
         presc   <= '0;
         cs_out  <= 7'd0;
         sec_out <= 6'd0;
         min_out <= '0;
      end else begin
         state   <= state_nx;
         running <= (state_nx == RUN);
         expired <= !clear && tick && down_zero;
         if (state == IDLE) mode_q <= mode;
         if (clear)              presc <= '0;
         else if (state == RUN)  presc <= tick ? '0 : presc + 1'b1;
         if (clear) begin
            if (mode) begin
               cs_out  <= (load_cs  > 7'd99) ? 7'd99 : load_cs;
               sec_out <= (load_sec > 6'd59) ? 6'd59 : load_sec;
               min_out <= (load_min > MIN_W'(MAX_MIN - 1)) ? MIN_W'(MAX_MIN - 1) : load_min;
            end else begin
               cs_out  <= 7'd0;
               sec_out <= 6'd0;
               min_out <= '0;
            end
         end else if (tick) begin
            cs_out  <= cs_nx;
            sec_out <= sec_nx;
            min_out <= min_nx;
         end
      end
   end

   // Lap FIFO: circular buffer, occupancy counter distinguishes full from empty
   lap_t          mem [LAP_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push_req, push, pop, full;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(LAP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count == CW'(LAP_DEPTH));
   assign push_req = lap && !clear && ((state == RUN) || (state == PAUSE));
   assign pop      = lap_rd && !clear && (count != '0);
   assign push     = push_req && (!full || pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         lap_ovf <= 1'b0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         lap_ovf <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (push_req && full && !pop) lap_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{min: min_out, sec: sec_out, cs: cs_out};
   end

   lap_t head;
   assign head      = (count != '0) ? mem[rd_ptr] : '0;
   assign lap_cs    = head.cs;
   assign lap_sec   = head.sec;
   assign lap_min   = head.min;
   assign lap_valid = (count != '0);
   assign lap_full  = full;

endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Parametrised successor of the up-counting stopwatch. It adds an internal tick prescaler, a configurable minute range, a down-count timer mode with load and expiry, start/pause control through an FSM, and a lap-capture FIFO. It sits between the debounced button pulses and the display/readout logic of the clock.

Parameters:
TICK_DIV, 100000, clk cycles per centisecond tick (>=1); 1 means every RUN cycle ticks.
MAX_MIN, 60, minute range; minutes count 0..MAX_MIN-1 (>=1).
LAP_DEPTH, 4, lap FIFO entries (>=2).
MIN_W = max(1, clog2(MAX_MIN)) is derived, not overridable.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse: start/pause toggle
clear  in  1  single-cycle pulse: return to IDLE, reload count, empty FIFO
mode  in  1  0 = count up (stopwatch), 1 = count down (timer); sampled only in IDLE
load_cs  in  7  timer preset, centiseconds
load_sec  in  6  timer preset, seconds
load_min  in  MIN_W  timer preset, minutes
lap  in  1  single-cycle pulse: capture current value
lap_rd  in  1  pop the FIFO head
cs_out  out  7  centiseconds 0..99
sec_out  out  6  seconds 0..59
min_out  out  MIN_W  minutes 0..MAX_MIN-1
running  out  1  high in RUN
expired  out  1  one-cycle pulse when the timer reaches zero
lap_cs / lap_sec / lap_min  out  7/6/MIN_W  FIFO head (first-word fall-through); 0 when empty
lap_valid  out  1  FIFO not empty
lap_full  out  1  FIFO holds LAP_DEPTH entries
lap_ovf  out  1  sticky: a lap was dropped; cleared by clear/reset

Behaviour:
- Reset: all outputs 0, FSM=IDLE, prescaler=0, FIFO empty.
- FSM states IDLE, RUN, PAUSE, DONE. Transitions occur on the edge after the input pulse.
  - IDLE+start -> RUN. Exception: mode=1 with count 0:00:00 stays IDLE.
  - RUN+start -> PAUSE; PAUSE+start -> RUN; DONE+start is ignored.
  - clear from any state -> IDLE. clear has priority over start and lap in the same cycle.
- Count on clear: mode=1 loads the preset with saturation: cs>99 -> 99, sec>59 -> 59, min>MAX_MIN-1 -> MAX_MIN-1. mode=0 loads 0:00:00. The mode latched in IDLE governs RUN/PAUSE; mode changes outside IDLE have no effect until the next IDLE.
- Prescaler: increments only in RUN and holds in PAUSE. The tick fires on the cycle it equals TICK_DIV-1, then it wraps to 0. It is zeroed by clear and reset.
- Up count on tick: cs+1; at 99 -> cs=0 with sec carry; at 59 -> sec=0 with min carry. MAX_MIN-1:59:99 wraps to 0:00:00 and the count continues running.
- Down count on tick: borrow chain (cs 0 -> 99 with sec borrow; sec 0 -> 59 with min borrow).
  - When the post-tick value is 0:00:00, on that same edge: state <= DONE, expired <= 1 (for one cycle), running <= 0.
  - Count holds at zero in DONE.
- running is registered and equals (state==RUN).
- Lap push: lap in RUN or PAUSE captures the cs/sec/min outputs as presented in that cycle, i.e. the pre-update value. lap in IDLE or DONE is ignored.
- FIFO rules:
  - Push when full: entry dropped, lap_ovf <= 1.
  - lap_rd when empty: ignored.
  - Simultaneous push and pop: both occur, count unchanged, no overflow even when full.
  - clear empties the FIFO and clears lap_ovf.
- All state is updated on posedge clk; no combinational paths from inputs to outputs except the FIFO head mux.

Test Plan:
- Up count (TICK_DIV=2): reset, start, run 200 cycles -> cs_out=0, sec_out=1, running=1. Pulse start, wait 20 cycles -> values unchanged, running=0.
- Wrap (MAX_MIN=2, TICK_DIV=1): run from 0 for 12000 ticks -> 1:59:99 after 11999 ticks, 0:00:00 on the next tick, still RUN.
- Timer: mode=1, load 0:01:05, clear, start, TICK_DIV=1 -> 0:00:00 after 105 ticks. expired high exactly 1 cycle, state DONE, start ignored, clear reloads 0:01:05.
- Saturation and zero preset: load_cs=120, load_sec=63 with mode=1, clear -> cs_out=99, sec_out=59. Preset 0:00:00 then start -> stays IDLE, running=0.
- Lap FIFO (LAP_DEPTH=4): 5 lap pulses while running -> lap_full=1, lap_ovf=1, head equals the first capture. Pop 4 -> values in capture order, then lap_valid=0 and head=0. lap+lap_rd together when full -> no ovf change.
- Priority and async reset: clear+start in the same cycle -> IDLE. reset asserted mid-RUN between clock edges -> outputs 0 immediately, FIFO empty.
